// File: rtl/gfx_vram_resp_if.sv
// if_axib: AXI4 burst bus subset used between the graphics core and its VRAM.
//   32-bit data, 32-bit byte address, 4-bit IDs, AW/W/B/AR/R channels.
//   Burst size/type signals are not carried; every burst is INCR of 32-bit beats.
//   modport s : responder side, modport m : requester side.
interface if_axib;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport s (
        input  awid, awaddr, awlen, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid,  output wready,
        output bid, bresp, bvalid,           input  bready,
        input  arid, araddr, arlen, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

    modport m (
        output awid, awaddr, awlen, awvalid, input  awready,
        output wdata, wstrb, wlast, wvalid,  input  wready,
        input  bid, bresp, bvalid,           output bready,
        output arid, araddr, arlen, arvalid, input  arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );
endinterface

// File: rtl/gfx_vram_resp.sv
// gfx_vram_resp: AXI4 burst responder backing the graphics core's VRAM port
// with an internal single-port synchronous RAM (1-cycle read latency).
// One transaction at a time; AW/AR ties alternate, first tie goes to read.
//
// Ports:
//   clk   core clock
//   rst   asynchronous active-high reset
//   axis  if_axib responder (AW/W/B/AR/R)
//   busy  high while a transaction is being served
//
// Parameters:
//   DEPTH_LOG2  log2 of RAM depth in 32-bit words
//   INIT_FILE   image name; RAM contents start X
//
// Build option:
//   GFX_VRAM_RESP_WSTRB_EN  when defined, wstrb selects written byte lanes;
//                           otherwise every W beat writes the full word.
module gfx_vram_resp #(
    parameter int unsigned DEPTH_LOG2 = 16,
    parameter string       INIT_FILE  = ""
) (
    input  logic clk,
    input  logic rst,
    if_axib.s    axis,
    output logic busy
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RADDR, RDRAIN} state_t;
    state_t state, state_nx;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           ram_q;

    logic [3:0]            id_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  oob_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic                  werr_q;
    logic                  prefer_rd_q;

    // Read return path: one RAM read in flight plus a 2-entry skid buffer.
    logic                  rd_pend_q, pend_err_q, pend_last_q;
    logic [1:0]            cnt_q;
    logic [31:0]           data0_q, data1_q;
    logic                  err0_q, err1_q, last0_q, last1_q;

    logic                  grant_r, grant_w, w_hs, r_pop, issue, last_beat;
    logic [31:0]           hs_addr;
    logic [3:0]            hs_id;
    logic [7:0]            hs_len;
    logic [1:0]            fill, occ;
    logic [31:0]           push_data;

    always_comb begin
        grant_r = 1'b0;
        grant_w = 1'b0;
        if (state == IDLE) begin
            grant_r = axis.arvalid && (!axis.awvalid || prefer_rd_q);
            grant_w = axis.awvalid && !grant_r;
        end
        hs_addr   = grant_r ? axis.araddr : axis.awaddr;
        hs_id     = grant_r ? axis.arid   : axis.awid;
        hs_len    = grant_r ? axis.arlen  : axis.awlen;
        w_hs      = (state == WDATA) && axis.wvalid;
        r_pop     = (cnt_q != 2'd0) && axis.rready;
        last_beat = (beat_q == len_q);
        // Slots taken next cycle if nothing new is issued: buffered beats
        // after this cycle's pop plus the RAM read already in flight.
        fill      = cnt_q - {1'b0, r_pop};
        occ       = fill + {1'b0, rd_pend_q};
        issue     = (state == RADDR) && (occ != 2'd2);
        push_data = pend_err_q ? '0 : ram_q;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (grant_r) state_nx = RADDR;
                    else if (grant_w) state_nx = WDATA;
            WDATA:  if (w_hs && (axis.wlast || last_beat)) state_nx = WRESP;
            WRESP:  if (axis.bready) state_nx = IDLE;
            RADDR:  if (issue && last_beat) state_nx = RDRAIN;
            RDRAIN: if (r_pop && last0_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign axis.awready = grant_w;
    assign axis.arready = grant_r;
    assign axis.wready  = (state == WDATA);
    assign axis.bvalid  = (state == WRESP);
    assign axis.bid     = id_q;
    assign axis.bresp   = {werr_q, 1'b0};
    assign axis.rvalid  = (cnt_q != 2'd0);
    assign axis.rid     = id_q;
    assign axis.rdata   = data0_q;
    assign axis.rresp   = {err0_q, 1'b0};
    assign axis.rlast   = last0_q;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prefer_rd_q <= 1'b1;
            id_q        <= '0;
            idx_q       <= '0;
            oob_q       <= 1'b0;
            len_q       <= '0;
            beat_q      <= '0;
            werr_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            pend_err_q  <= 1'b0;
            pend_last_q <= 1'b0;
            cnt_q       <= '0;
            data0_q     <= '0;
            data1_q     <= '0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant_r || grant_w) begin
                prefer_rd_q <= grant_w;
                id_q        <= hs_id;
                idx_q       <= hs_addr[DEPTH_LOG2+1:2];
                oob_q       <= |hs_addr[31:DEPTH_LOG2+2];
                len_q       <= hs_len;
                beat_q      <= '0;
                werr_q      <= 1'b0;
            end
            if (w_hs || issue) begin
                idx_q  <= idx_q + DEPTH_LOG2'(1);
                beat_q <= beat_q + 8'd1;
            end
            // wlast disagreeing with the beat count in either direction errs.
            if (w_hs)
                werr_q <= werr_q | oob_q | (axis.wlast != last_beat);

            rd_pend_q <= issue;
            if (issue) begin
                pend_err_q  <= oob_q;
                pend_last_q <= last_beat;
            end
            if (r_pop) begin
                data0_q <= data1_q;
                err0_q  <= err1_q;
                last0_q <= last1_q;
            end
            if (rd_pend_q) begin
                if (fill == 2'd0) begin
                    data0_q <= push_data;
                    err0_q  <= pend_err_q;
                    last0_q <= pend_last_q;
                end else begin
                    data1_q <= push_data;
                    err1_q  <= pend_err_q;
                    last1_q <= pend_last_q;
                end
            end
            cnt_q <= occ;
        end
    end

    // Single RAM port: writes from W beats, reads issued from RADDR.
    always_ff @(posedge clk) begin
        if (w_hs && !oob_q) begin
`ifdef GFX_VRAM_RESP_WSTRB_EN
            for (int unsigned b = 0; b < 4; b++)
                if (axis.wstrb[b])
                    mem[idx_q][8*b +: 8] <= axis.wdata[8*b +: 8];
`else
            mem[idx_q] <= axis.wdata;
`endif
        end
        if (issue)
            ram_q <= mem[idx_q];
    end

    logic unused_bits;
`ifdef GFX_VRAM_RESP_WSTRB_EN
    assign unused_bits = ^hs_addr[1:0];
`else
    assign unused_bits = ^{hs_addr[1:0], axis.wstrb};
`endif
endmodule

// File: tb/tb_gfx_vram_resp.sv
module tb_gfx_vram_resp;
    logic clk;
    logic rst;
    logic busy;

    if_axib bus ();

    gfx_vram_resp #(.DEPTH_LOG2(16), .INIT_FILE("")) dut (
        .clk  (clk),
        .rst  (rst),
        .axis (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    logic [31:0] wbuf     [0:255];
    logic [31:0] cap_data [0:255];
    logic [1:0]  cap_resp [0:255];
    logic        cap_last [0:255];
    logic [3:0]  cap_id;
    int          cap_n, cap_first, cap_lastk, stall_bad;
    logic [1:0]  wr_resp;
    logic [3:0]  wr_bid;

    // ---------------- stimulus helpers (start and end on a negedge) -------
    task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        logic done;
        bus.awid = id; bus.awaddr = a; bus.awlen = l; bus.awvalid = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            #1; done = bus.awready;
            @(negedge clk);
        end
        bus.awvalid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL aw_handshake: got no awready, expected awready within 50 cycles");
        end
    endtask

    task automatic w_phase(input int nsend, input int last_at, input logic [3:0] strb);
        logic done;
        for (int b = 0; b < nsend; b++) begin
            bus.wvalid = 1'b1; bus.wdata = wbuf[b]; bus.wstrb = strb;
            bus.wlast = (b == last_at);
            done = 1'b0;
            for (int n = 0; n < 50 && !done; n++) begin
                #1; done = bus.wready;
                @(negedge clk);
            end
            if (!done) begin
                checks++; errors++;
                $display("FAIL w_handshake: beat %0d got no wready, expected wready", b);
                break;
            end
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        bus.bready = 1'b1;
        done = 1'b0;
        wr_resp = 2'bxx;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (bus.bvalid) begin done = 1'b1; wr_resp = bus.bresp; wr_bid = bus.bid; end
            @(negedge clk);
        end
        bus.bready = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL b_handshake: got no bvalid, expected bvalid within 50 cycles");
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] l, input int nsend,
                            input int last_at, input logic [3:0] strb, input logic [3:0] id);
        aw_send(a, l, id);
        w_phase(nsend, last_at, strb);
    endtask

    // rmode 0: rready always high; rmode 1: rready high on every third cycle.
    task automatic r_phase(input int rmode);
        logic        seen_last, prev_stall, prev_last;
        logic [31:0] prev_data;
        cap_n = 0; cap_first = -1; cap_lastk = -1; stall_bad = 0;
        seen_last = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        for (int k = 0; k < 3000 && !seen_last; k++) begin
            bus.rready = (rmode == 0) || (k % 3 == 0);
            #1;
            if (prev_stall && (!bus.rvalid || bus.rdata !== prev_data || bus.rlast !== prev_last))
                stall_bad++;
            prev_stall = bus.rvalid && !bus.rready;
            prev_data = bus.rdata; prev_last = bus.rlast;
            if (bus.rvalid && cap_first < 0) cap_first = k;
            if (bus.rvalid && bus.rready) begin
                if (cap_n < 256) begin
                    cap_data[cap_n] = bus.rdata;
                    cap_resp[cap_n] = bus.rresp;
                    cap_last[cap_n] = bus.rlast;
                end
                cap_id = bus.rid;
                cap_n++;
                seen_last = bus.rlast;
                cap_lastk = k;
            end
            @(negedge clk);
        end
        bus.rready = 1'b0;
        if (!seen_last) begin
            checks++; errors++;
            $display("FAIL r_rlast_timeout: got %0d beats without rlast, expected rlast", cap_n);
        end
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        logic done;
        bus.arid = id; bus.araddr = a; bus.arlen = l; bus.arvalid = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            #1; done = bus.arready;
            @(negedge clk);
        end
        bus.arvalid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL ar_handshake: got no arready, expected arready within 50 cycles");
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                           input int rmode);
        ar_send(a, l, id);
        r_phase(rmode);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------------------------------------
    task automatic test_reset();
        logic [5:0] got;
        #1;
        got = {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, busy};
        checks++;
        if (got !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000 (awr,arr,wr,bv,rv,busy)", got);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        wbuf[0] = 32'hDEADBEEF;
        do_write(32'h0000_0100, 8'd0, 1, 0, 4'hF, 4'h3);
        checks++;
        if (wr_resp !== 2'd0 || wr_bid !== 4'h3) begin
            errors++;
            $display("FAIL single_bresp: got resp %0d id %h expected resp 0 id 3", wr_resp, wr_bid);
        end
        do_read(32'h0000_0100, 8'd0, 4'h5, 0);
        checks++;
        if (cap_n !== 1 || cap_data[0] !== 32'hDEADBEEF || cap_last[0] !== 1'b1 || cap_resp[0] !== 2'd0) begin
            errors++;
            $display("FAIL single_read: got n=%0d data %h last %b resp %0d expected n=1 data deadbeef last 1 resp 0",
                     cap_n, cap_data[0], cap_last[0], cap_resp[0]);
        end
        checks++;
        if (cap_first !== 2 || cap_id !== 4'h5) begin
            errors++;
            $display("FAIL single_latency: got first rvalid %0d rid %h expected 2 and 5", cap_first, cap_id);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_burst_backpressure();
        int bad;
        for (int i = 0; i < 16; i++) wbuf[i] = i;
        do_write(32'h0000_2000, 8'd15, 16, 15, 4'hF, 4'h1);
        checks++;
        if (wr_resp !== 2'd0) begin
            errors++;
            $display("FAIL burst_bresp: got %0d expected 0", wr_resp);
        end
        do_read(32'h0000_2000, 8'd15, 4'h2, 1);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (cap_data[i] !== 32'(i) || cap_last[i] !== (i == 15) || cap_resp[i] !== 2'd0) bad++;
        checks++;
        if (cap_n !== 16 || bad !== 0) begin
            errors++;
            $display("FAIL burst_bp_data: got %0d beats %0d bad expected 16 beats 0 bad", cap_n, bad);
        end
        checks++;
        if (stall_bad !== 0) begin
            errors++;
            $display("FAIL burst_bp_hold: got %0d unstable stalled beats expected 0", stall_bad);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_bp_extra: got rvalid %b busy %b expected 0 0", bus.rvalid, busy);
        end
        do_read(32'h0000_2000, 8'd15, 4'h2, 0);
        checks++;
        if (cap_n !== 16 || cap_lastk - cap_first !== 15 || cap_data[15] !== 32'd15) begin
            errors++;
            $display("FAIL burst_rate: got %0d beats over %0d cycles last %h expected 16 over 15 last f",
                     cap_n, cap_lastk - cap_first, cap_data[15]);
        end
    endtask

    task automatic test_arbitration();
        logic got_r, got_w, exp_r;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_r = (i % 2 == 0);
            bus.awid = 4'h1; bus.awaddr = 32'h0000_0300; bus.awlen = 8'd0; bus.awvalid = 1'b1;
            bus.arid = 4'h2; bus.araddr = 32'h0000_0100; bus.arlen = 8'd0; bus.arvalid = 1'b1;
            #1;
            got_r = bus.arready; got_w = bus.awready;
            checks++;
            if (got_r !== exp_r || got_w !== !exp_r) begin
                errors++;
                $display("FAIL arb_tie_%0d: got arready %b awready %b expected %b %b",
                         i, got_r, got_w, exp_r, !exp_r);
            end
            @(negedge clk);
            bus.awvalid = 1'b0; bus.arvalid = 1'b0;
            if (got_w) begin
                wbuf[0] = 32'hA000_0000 + i;
                w_phase(1, 0, 4'hF);
            end else if (got_r) begin
                r_phase(0);
                if (i == 0) begin
                    checks++;
                    if (cap_data[0] !== 32'hDEADBEEF) begin
                        errors++;
                        $display("FAIL arb_ram_persist: got %h expected deadbeef", cap_data[0]);
                    end
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        wbuf[0] = 32'h5A5A_0000;
        do_write(32'h0000_0000, 8'd0, 1, 0, 4'hF, 4'h0);
        do_read(32'h0010_0000, 8'd1, 4'h6, 0);
        checks++;
        if (cap_n !== 2 || cap_data[0] !== 32'd0 || cap_data[1] !== 32'd0 || cap_resp[0] !== 2'd2 ||
            cap_resp[1] !== 2'd2 || cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL oob_read: got n=%0d d0 %h d1 %h r0 %0d r1 %0d expected n=2 zeros resp 2",
                     cap_n, cap_data[0], cap_data[1], cap_resp[0], cap_resp[1]);
        end
        wbuf[0] = 32'hFFFF_FFFF;
        do_write(32'h0010_0000, 8'd0, 1, 0, 4'hF, 4'h0);
        checks++;
        if (wr_resp !== 2'd2) begin
            errors++;
            $display("FAIL oob_bresp: got %0d expected 2", wr_resp);
        end
        do_read(32'h0000_0000, 8'd0, 4'h0, 0);
        checks++;
        if (cap_data[0] !== 32'h5A5A_0000) begin
            errors++;
            $display("FAIL oob_ram_unchanged: got %h expected 5a5a0000", cap_data[0]);
        end
    endtask

    task automatic test_wlast_mismatch();
        wbuf[0] = 32'h1; wbuf[1] = 32'h2;
        do_write(32'h0000_0500, 8'd3, 1, 0, 4'hF, 4'h0);
        checks++;
        if (wr_resp !== 2'd2) begin
            errors++;
            $display("FAIL wlast_early: got %0d expected 2", wr_resp);
        end
        do_write(32'h0000_0600, 8'd1, 2, 99, 4'hF, 4'h0);
        checks++;
        if (wr_resp !== 2'd2) begin
            errors++;
            $display("FAIL wlast_missing: got %0d expected 2", wr_resp);
        end
        do_write(32'h0000_0600, 8'd1, 2, 1, 4'hF, 4'h0);
        checks++;
        if (wr_resp !== 2'd0) begin
            errors++;
            $display("FAIL wlast_recover: got %0d expected 0", wr_resp);
        end
    endtask

    task automatic test_reset_mid_burst();
        int got;
        logic hit;
        ar_send(32'h0000_2000, 8'd9, 4'h4);
        got = 0; hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            bus.rready = 1'b1;
            #1;
            if (bus.rvalid) begin
                if (got == 5) begin
                    hit = 1'b1;
                    rst = 1'b1;
                    #1;
                    break;
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit || bus.rvalid !== 1'b0 || busy !== 1'b0 || bus.arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst: got reached %b rvalid %b busy %b expected 1 0 0",
                     hit, bus.rvalid, busy);
        end
        @(negedge clk);
        bus.rready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        do_read(32'h0000_2014, 8'd0, 4'h7, 0);
        checks++;
        if (cap_n !== 1 || cap_data[0] !== 32'd5 || cap_resp[0] !== 2'd0 || cap_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_recover_read: got n=%0d data %h expected n=1 data 5", cap_n, cap_data[0]);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] exp;
`ifdef GFX_VRAM_RESP_WSTRB_EN
        exp = 32'h11BB33DD;
`else
        exp = 32'hAABBCCDD;
`endif
        wbuf[0] = 32'h11223344;
        do_write(32'h0000_0400, 8'd0, 1, 0, 4'hF, 4'h0);
        wbuf[0] = 32'hAABBCCDD;
        do_write(32'h0000_0400, 8'd0, 1, 0, 4'b0101, 4'h0);
        do_read(32'h0000_0400, 8'd0, 4'h0, 0);
        checks++;
        if (cap_data[0] !== exp) begin
            errors++;
            $display("FAIL strobe_merge: got %h expected %h", cap_data[0], exp);
        end
    endtask

    task automatic test_len255_and_wrap();
        int bad;
        for (int i = 0; i < 256; i++) wbuf[i] = 32'h5000_0000 | 32'(i);
        do_write(32'h0000_8000, 8'd255, 256, 255, 4'hF, 4'h0);
        checks++;
        if (wr_resp !== 2'd0) begin
            errors++;
            $display("FAIL len255_bresp: got %0d expected 0", wr_resp);
        end
        do_read(32'h0000_8000, 8'd255, 4'h9, 0);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (cap_data[i] !== (32'h5000_0000 | 32'(i)) || cap_last[i] !== (i == 255)) bad++;
        checks++;
        if (cap_n !== 256 || bad !== 0 || cap_lastk - cap_first !== 255) begin
            errors++;
            $display("FAIL len255_read: got %0d beats %0d bad span %0d expected 256 0 255",
                     cap_n, bad, cap_lastk - cap_first);
        end
        wbuf[0] = 32'hCAFE_0001; wbuf[1] = 32'hCAFE_0002;
        do_write(32'h0003_FFFC, 8'd1, 2, 1, 4'hF, 4'h0);
        do_read(32'h0000_0000, 8'd0, 4'h0, 0);
        checks++;
        if (cap_data[0] !== 32'hCAFE_0002) begin
            errors++;
            $display("FAIL wrap_index: got %h expected cafe0002", cap_data[0]);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_single();
        test_burst_backpressure();
        test_arbitration();
        test_out_of_range();
        test_wlast_mismatch();
        test_reset_mid_burst();
        test_strobe();
        test_len255_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
